// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk of full-adder cells per register stage, valid/ready at both ends.
module rca_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // CHUNK full-adder cells in a ripple chain; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        logic [CHUNK-1:0] sum;
        logic             c;
        c = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, sum};
    endfunction

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operands entering each stage: the unconsumed chunks are kept right-aligned,
    // so every stage works on bits [CHUNK-1:0] of its a/b inputs.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             c_in   [STAGES];
    logic             vld_in [STAGES];

    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] b_p    [STAGES];
    logic [WIDTH-1:0] sum_p  [STAGES];
    logic             c_p    [STAGES];
    logic             vld_p  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   chunk_res;
        logic [WIDTH-1:0] sum_nxt;

        if (k == 0) begin : g_src
            // Stage 0 boundary: subtraction becomes A + ~B + 1 here
            assign a_in[0]   = a;
            assign b_in[0]   = b ^ {WIDTH{sub}};
            assign sum_in[0] = '0;
            assign c_in[0]   = sub | ci;
            assign vld_in[0] = in_valid;
        end else begin : g_link
            // Stage k boundary: consume the registered state of stage k-1
            assign a_in[k]   = a_p[k-1];
            assign b_in[k]   = b_p[k-1];
            assign sum_in[k] = sum_p[k-1];
            assign c_in[k]   = c_p[k-1];
            assign vld_in[k] = vld_p[k-1];
        end

        assign chunk_res = chunk_add(a_in[k][CHUNK-1:0], b_in[k][CHUNK-1:0], c_in[k]);

        always_comb begin
            sum_nxt = sum_in[k];
            sum_nxt[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_p[k] <= 1'b0;
                end else if (advance) begin
                    vld_p[k] <= vld_in[k];
                end
            end

            // Data only moves with a valid operation, so bubbles never clobber it
            always_ff @(posedge clk) begin
                if (advance && vld_in[k]) begin
                    a_p[k]   <= a_in[k] >> CHUNK;
                    b_p[k]   <= b_in[k] >> CHUNK;
                    sum_p[k] <= sum_nxt;
                    c_p[k]   <= chunk_res[CHUNK];
                end
            end
        end else begin : g_last
            // Output boundary: the last chunk holds the MSB of a and b_eff for ovf
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    co        <= 1'b0;
                    ovf       <= 1'b0;
                end else if (advance) begin
                    out_valid <= vld_in[k];
                    if (vld_in[k]) begin
                        s   <= sum_nxt;
                        co  <= chunk_res[CHUNK];
                        ovf <= (a_in[k][CHUNK-1] == b_in[k][CHUNK-1]) &&
                               (chunk_res[CHUNK-1] != a_in[k][CHUNK-1]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: directed 32/4 scenarios plus randomised
// (4,1) exhaustive, (8,2) and (16,16) sweeps against a behavioural model.
module tb_rca_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model, packed as {ovf, co, s[w-1:0]}
    function automatic logic [63:0] ref_add(input int w, input logic [31:0] av,
                                            input logic [31:0] bv, input logic civ,
                                            input logic subv);
        logic [33:0] mask, be, full;
        logic [31:0] sm;
        logic        cov, ovv;
        mask = (34'd1 << w) - 34'd1;
        be   = subv ? (~{2'b00, bv} & mask) : {2'b00, bv};
        full = {2'b00, av} + be + {33'd0, (subv ? 1'b1 : civ)};
        sm   = full[31:0] & mask[31:0];
        cov  = full[w];
        ovv  = (av[w-1] == be[w-1]) && (sm[w-1] != av[w-1]);
        return 64'(sm) | (64'(cov) << w) | (64'(ovv) << (w + 1));
    endfunction

    logic [63:0] q_main[$];
    logic        last_ov, last_ir;
    logic [31:0] last_s;

    task automatic main_cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                              input logic ici, input logic isub, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        sub       = isub;
        out_ready = ordy;
        #1;
        last_ov = out_valid;
        last_ir = in_ready;
        last_s  = s;
        if (out_valid && out_ready) begin
            if (q_main.size() == 0) check("main_unexpected_out", 64'(s), 64'hdead_0000);
            else check("main_res", {31'd0, ovf, co, s}, q_main.pop_front());
        end
        if (in_valid && in_ready) q_main.push_back(ref_add(32, ia, ib, ici, isub));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) main_cycle(1'b0, 32'hA5A5_5A5A, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    endtask

    // Parameter sweep instances, each with its own reset and scoreboard
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 16;

        logic         rst_n, iv, ir, ov, orr, c_i, sb, co_o, ovf_o, done;
        logic [W-1:0] aa, bb, ss;
        logic [63:0]  q[$];
        logic [63:0]  held;
        logic         was_stall;
        int           idx, cyc, lat, total;

        rca_pipe #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk(clk), .reset_n(rst_n),
            .in_valid(iv), .in_ready(ir),
            .a(aa), .b(bb), .ci(c_i), .sub(sb),
            .out_valid(ov), .out_ready(orr),
            .s(ss), .co(co_o), .ovf(ovf_o)
        );

        initial begin
            done = 1'b0; rst_n = 1'b0; iv = 1'b0; orr = 1'b1;
            aa = '0; bb = '0; c_i = 1'b0; sb = 1'b0;
            was_stall = 1'b0; held = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("sw_reset_valid", 64'(ov), 64'd0);

            // Latency with an empty pipeline and out_ready held high
            @(negedge clk);
            iv = 1'b1; aa = W'($urandom); bb = W'($urandom); c_i = 1'b1; sb = 1'b0;
            #1;
            q.push_back(ref_add(W, 32'(aa), 32'(bb), c_i, sb));
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            iv = 1'b0;
            #1;
            while (!ov && lat < 60) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                #1;
            end
            check("sw_latency", 64'(lat), 64'(S));
            if (ov) check("sw_lat_res", 64'({ovf_o, co_o, ss}), q.pop_front());

            idx = 0; cyc = 0;
            total = (g == 0) ? 2024 : 1000;
            while ((idx < total || q.size() > 0) && cyc < 20000) begin
                @(negedge clk);
                if (idx < total) begin
                    iv = ($urandom_range(0, 3) != 0);
                    if (g == 0 && idx < 1024) begin
                        bb  = W'(idx & 15);
                        aa  = W'((idx >> 4) & 15);
                        c_i = 1'((idx >> 8) & 1);
                        sb  = 1'((idx >> 9) & 1);
                    end else begin
                        aa  = W'($urandom);
                        bb  = W'($urandom);
                        c_i = 1'($urandom);
                        sb  = 1'($urandom);
                    end
                end else begin
                    iv = 1'b0;
                end
                orr = ($urandom_range(0, 3) != 0);
                #1;
                if (was_stall) check("sw_hold", 64'({ov, ovf_o, co_o, ss}), held);
                if (ov && orr) begin
                    if (q.size() == 0) check("sw_unexpected_out", 64'(ss), 64'hdead_0000);
                    else check("sw_res", 64'({ovf_o, co_o, ss}), q.pop_front());
                end
                was_stall = ov && !orr;
                held      = 64'({ov, ovf_o, co_o, ss});
                if (iv && ir) begin
                    q.push_back(ref_add(W, 32'(aa), 32'(bb), c_i, sb));
                    idx++;
                end
                cyc++;
            end
            check("sw_drained", 64'(q.size()), 64'd0);
            check("sw_all_sent", 64'(idx), 64'(total));
            done = 1'b1;
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
        last_ov = 1'b0; last_ir = 1'b0; last_s = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", {31'd0, ovf, co, s}, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Carry through every stage boundary, latency of four edges
        main_cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("lat_not_yet", 64'(last_ov), 64'd0);
        end
        idle(1);
        check("lat_arrive", 64'(last_ov), 64'd1);
        check("carry_chain", {31'd0, ovf, co, s}, 64'h1_0000_0000);

        // Signed overflow, then subtract with ci ignored
        main_cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        idle(6);

        // Streaming with a three-cycle output stall
        main_cycle(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'd10, 32'd3, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            main_cycle(1'b1, 32'hBAD0_0000, 32'h0000_0BAD, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", 64'(last_ir), 64'd0);
            check("stall_s_frozen", 64'(last_s), 64'd3);
            check("stall_valid", 64'(last_ov), 64'd1);
        end
        idle(8);
        check("stream_drained", 64'(q_main.size()), 64'd0);

        // Bubble between two operations
        main_cycle(1'b1, 32'd100, 32'd23, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1);
        main_cycle(1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
        idle(1);
        idle(1);
        check("bubble_v0", 64'(last_ov), 64'd1);
        idle(1);
        check("bubble_v1", 64'(last_ov), 64'd0);
        check("bubble_s_hold", 64'(last_s), 64'd123);
        idle(1);
        check("bubble_v2", 64'(last_ov), 64'd1);
        idle(3);

        // Reset with three operations in flight
        main_cycle(1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, 1'b1);
        main_cycle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        q_main.delete();
        @(negedge clk);
        #1;
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_data", {31'd0, ovf, co, s}, 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check("no_stale_out", 64'(last_ov), 64'd0);
        end
        main_cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("post_reset_lat_early", 64'(last_ov), 64'd0);
        idle(1);
        check("post_reset_lat", 64'(last_ov), 64'd1);
        idle(2);
        check("main_drained", 64'(q_main.size()), 64'd0);

        for (int t = 0; t < 60000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); t++)
            @(posedge clk);
        check("sweeps_done", 64'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 64'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
